rotation_result_fifo: RTL and testbench
=======================================

Name: rotation_result_fifo

Overview:
- Parametrised multi-lane synchronous FIFO that buffers rotation CORDIC results (x, y, z and optional extra lanes) between the CORDIC output and the Jacobi main controller.
- Replaces the direct wire-through between those two blocks.
- The CORDIC cannot stall, so the FIFO exports an almost-full credit signal. The controller uses it to throttle CORDIC issue, and the FIFO flags any overflow.

Parameters:
- DATA_W, default JACOBI_OUTPUT_WORD_WIDTH: width of one lane word.
- LANES, default 3: number of parallel words per entry (x, y, z).
- DEPTH, default 16: entries. Must be a power of two and at least 4.
- AFULL_LVL, default 12: level at or above which almost_full_o asserts. Legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (assert 0).
- clr_i  in  1  synchronous flush: empties the FIFO and clears overflow_o.
- in_dat_i  in  LANES*DATA_W  write entry; lane 0 occupies the LSBs.
- in_vld_i  in  1  write request.
- in_rdy_o  out  1  not full.
- out_dat_o  out  LANES*DATA_W  head entry.
- out_vld_o  out  1  FIFO not empty.
- out_rdy_i  in  1  consumer accepts the head entry.
- level_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full_o  out  1  level_o >= AFULL_LVL.
- overflow_o  out  1  sticky: a write was attempted while full.
- peak_level_o  out  $clog2(DEPTH)+1  maximum occupancy seen (optional feature).

Behaviour:
- Reset (rst=0, asynchronous): both pointers=0, level_o=0, out_vld_o=0, in_rdy_o=1, almost_full_o=0, overflow_o=0, peak_level_o=0.
  - Storage contents are not reset.
  - out_dat_o is don't-care while out_vld_o=0.
- Reset mid-operation: all buffered entries are discarded immediately. The first cycle after deassertion behaves as empty.
- Pointers: read and write pointers are ADDR_W+1 bits, where ADDR_W=$clog2(DEPTH). The MSB is the wrap bit.
  - empty = pointers equal.
  - full = addresses equal and wrap bits differ.
  - Natural binary wrap; no special case at DEPTH-1 -> 0.
- Push: occurs when in_vld_i && !full.
  - Entry is written at wr_ptr; wr_ptr increments.
- Pop: occurs when out_vld_o && out_rdy_i; rd_ptr increments.
- Show-ahead (first-word fall-through):
  - out_dat_o is combinationally mem[rd_addr].
  - An entry pushed in cycle N is visible with out_vld_o=1 in cycle N+1 (latency 1).
  - out_dat_o holds stable while out_vld_o=1 and out_rdy_i=0.
- Simultaneous push and pop:
  - Not full and not empty: both happen; level is unchanged.
  - Empty: only the push happens, because no pop is possible.
  - Full: only the pop happens. in_rdy_o=0 that cycle, the write is dropped, and overflow is set.
- in_rdy_o = !full. It is registered-state derived, with no combinational path from out_rdy_i.
- overflow_o: set on in_vld_i && full. Cleared only by reset or clr_i.
- clr_i:
  - Takes effect next edge: pointers and level go to 0, overflow_o goes to 0.
  - A push or pop in the same cycle as clr_i is ignored.
  - clr_i has priority over all other updates.
- level_o and almost_full_o are registered. They update on the edge of the push or pop and are exact each cycle.
- almost_full_o contract: the controller must stop issuing CORDIC operations while almost_full_o=1. DEPTH-AFULL_LVL must cover the CORDIC pipeline latency plus the in-flight count.

Optional Feature:
- Macro: ROTATION_RESULT_FIFO_PEAK_EN.
- Defined:
  - peak_level_o is a register updated each cycle to max(peak, next level).
  - It is cleared by reset and by clr_i.
- Undefined:
  - Register is not synthesised; peak_level_o is tied to 0.
  - Port list is identical in both builds.

Decomposition:
- In package common:
  - ROT_FIFO_DEPTH and ROT_FIFO_AFULL_LVL constants.
  - rot_word_t typedef, logic [JACOBI_OUTPUT_WORD_WIDTH-1:0].
  - rot_triplet_t packed struct {z, y, x}; x sits in the LSBs, matching lane 0.
- Sub-module fifo_ptr_ctrl (parameter DEPTH): owns the pointers, the full/empty decode and the level counter.
- Top level holds the storage array, overflow_o and the peak logic.

Test Plan:
- Reset then 1 push (x=1, y=2, z=3), out_rdy_i=0 -> next cycle out_vld_o=1, out_dat_o={3,2,1}, level_o=1. Data holds until out_rdy_i=1, then level_o=0 and out_vld_o=0.
- 16 pushes of value i (i=0..15), no pops -> almost_full_o rises on the cycle level_o=12 and in_rdy_o=0 at 16. A 17th push sets overflow_o=1, level stays 16. Draining then yields 0..15 in order.
- Continuous push and pop for 40 cycles at level 5 -> level_o constant at 5; output sequence is in order across 2 pointer wraps.
- Full FIFO with in_vld_i=1 and out_rdy_i=1 in the same cycle -> pop happens, push is dropped, overflow_o=1, level_o=15.
- Level 7 with overflow_o=1, pulse clr_i -> next cycle level_o=0, out_vld_o=0, overflow_o=0. With the macro defined, peak_level_o=0.
- Level 9, assert rst=0 asynchronously mid-cycle -> all outputs at reset values before the next edge. A push after release appears at the head alone.

Source files
------------

// File: rtl/rotation_result_fifo_pkg.sv
// Shared types and default sizing for the rotation-result FIFO between the
// CORDIC output and the Jacobi main controller.
package rotation_result_fifo_pkg;

  localparam int unsigned JACOBI_OUTPUT_WORD_WIDTH = 16;

  localparam int unsigned ROT_FIFO_DEPTH     = 16;
  localparam int unsigned ROT_FIFO_AFULL_LVL = 12;

  typedef logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] rot_word_t;

  // x occupies the LSBs so it lines up with lane 0 of the FIFO entry.
  typedef struct packed {
    rot_word_t z;
    rot_word_t y;
    rot_word_t x;
  } rot_triplet_t;

endpackage

// File: rtl/rotation_result_fifo_if.sv
// Write/read handshake bundle for rotation_result_fifo; slave is the FIFO side,
// master is the producer/consumer side.
interface rotation_result_fifo_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 3
);

  logic [LANES*DATA_W-1:0] in_dat_i;
  logic                    in_vld_i;
  logic                    in_rdy_o;
  logic [LANES*DATA_W-1:0] out_dat_o;
  logic                    out_vld_o;
  logic                    out_rdy_i;

  modport slave (
    input  in_dat_i, in_vld_i, out_rdy_i,
    output in_rdy_o, out_dat_o, out_vld_o
  );

  modport master (
    output in_dat_i, in_vld_i, out_rdy_i,
    input  in_rdy_o, out_dat_o, out_vld_o
  );

endinterface

// File: rtl/rotation_result_fifo_ptr_ctrl.sv
// Pointer, full/empty decode and occupancy counter for rotation_result_fifo.
// Pointers carry one extra wrap bit above the address.
module fifo_ptr_ctrl #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_req_i,
  input  logic                     pop_req_i,
  output logic [$clog2(DEPTH)-1:0] wr_addr_o,
  output logic [$clog2(DEPTH)-1:0] rd_addr_o,
  output logic                     push_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   level_nxt_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] level_q,  level_d;
  logic            full, empty, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign push  = push_req_i && !full;
  assign pop   = pop_req_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + ONE;
        2'b01:   level_d = level_q - ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign wr_addr_o   = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr_o   = rd_ptr_q[ADDR_W-1:0];
  assign push_o      = push && !clr_i;
  assign full_o      = full;
  assign empty_o     = empty;
  assign level_o     = level_q;
  assign level_nxt_o = level_d;

endmodule

// File: rtl/rotation_result_fifo.sv
// Multi-lane show-ahead FIFO for rotation CORDIC results with almost-full
// credit and sticky overflow. Optional peak tracker: ROTATION_RESULT_FIFO_PEAK_EN.
module rotation_result_fifo
  import rotation_result_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = JACOBI_OUTPUT_WORD_WIDTH,
  parameter int unsigned LANES     = 3,
  parameter int unsigned DEPTH     = ROT_FIFO_DEPTH,
  parameter int unsigned AFULL_LVL = ROT_FIFO_AFULL_LVL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  rotation_result_fifo_if.slave  bus,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   almost_full_o,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] peak_level_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam logic [LVL_W-1:0] AFULL_THR = LVL_W'(AFULL_LVL);

  logic [LANES*DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]       wr_addr, rd_addr;
  logic                    push, full, empty;
  logic [LVL_W-1:0]        level, level_nxt;
  logic                    afull_q, afull_d;
  logic                    overflow_q, overflow_d;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk         (clk),
    .rst_n       (rst),
    .clr_i       (clr_i),
    .push_req_i  (bus.in_vld_i),
    .pop_req_i   (bus.out_rdy_i),
    .wr_addr_o   (wr_addr),
    .rd_addr_o   (rd_addr),
    .push_o      (push),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level),
    .level_nxt_o (level_nxt)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_addr] <= bus.in_dat_i;
  end

  assign bus.out_dat_o = mem_q[rd_addr];
  assign bus.out_vld_o = !empty;
  assign bus.in_rdy_o  = !full;

  always_comb begin
    afull_d    = (level_nxt >= AFULL_THR);
    overflow_d = overflow_q;
    if (clr_i)                   overflow_d = 1'b0;
    else if (bus.in_vld_i && full) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      afull_q    <= afull_d;
      overflow_q <= overflow_d;
    end
  end

  assign level_o       = level;
  assign almost_full_o = afull_q;
  assign overflow_o    = overflow_q;

`ifdef ROTATION_RESULT_FIFO_PEAK_EN
  logic [LVL_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (clr_i)                  peak_d = '0;
    else if (level_nxt > peak_q) peak_d = level_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) peak_q <= '0;
    else      peak_q <= peak_d;
  end

  assign peak_level_o = peak_q;
`else
  assign peak_level_o = '0;
`endif

endmodule

// File: tb/tb_rotation_result_fifo.sv
// Self-checking bench for rotation_result_fifo against a queue-based model.
module tb_rotation_result_fifo;
  import rotation_result_fifo_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned LN = 3;
  localparam int unsigned DP = 16;
  localparam int unsigned AF = 12;
  localparam int unsigned W  = DW * LN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic [4:0] level, peak;
  logic afull, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mq[$];
  bit           m_ovf;
  int           m_peak;

  rotation_result_fifo_if #(.DATA_W(DW), .LANES(LN)) bus ();

  rotation_result_fifo #(
    .DATA_W(DW), .LANES(LN), .DEPTH(DP), .AFULL_LVL(AF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (clr),
    .bus           (bus),
    .level_o       (level),
    .almost_full_o (afull),
    .overflow_o    (ovf),
    .peak_level_o  (peak)
  );

  always #5 clk = ~clk;

  function automatic int exp_peak();
`ifdef ROTATION_RESULT_FIFO_PEAK_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_ovf  = 1'b0;
    m_peak = 0;
  endfunction

  function automatic void model_edge(input bit c, input bit v, input bit r,
                                     input logic [W-1:0] d);
    bit was_full;
    if (c) begin
      model_clear();
      return;
    end
    was_full = (mq.size() == DP);
    if (v && was_full) m_ovf = 1'b1;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (v && !was_full) mq.push_back(d);
    if (mq.size() > m_peak) m_peak = mq.size();
  endfunction

  task automatic step(input bit c, input bit v, input bit r, input logic [W-1:0] d);
    @(negedge clk);
    clr = c; bus.in_vld_i = v; bus.out_rdy_i = r; bus.in_dat_i = d;
    @(posedge clk);
    model_edge(c, v, r, d);
    #1;
  endtask

  task automatic test_reset();
    bus.in_vld_i = 1'b0; bus.out_rdy_i = 1'b0; bus.in_dat_i = '0; clr = 1'b0;
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (level !== 5'd0 || bus.out_vld_o !== 1'b0 || bus.in_rdy_o !== 1'b1 ||
        afull !== 1'b0 || ovf !== 1'b0 || peak !== 5'd0) begin
      n_fail++;
      $display("FAIL reset: lvl=%0d vld=%b rdy=%b af=%b ovf=%b pk=%0d, want 0 0 1 0 0 0",
               level, bus.out_vld_o, bus.in_rdy_o, afull, ovf, peak);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single();
    rot_triplet_t t;
    logic [W-1:0] e;
    t = '{z: 16'd3, y: 16'd2, x: 16'd1};
    e = t;
    step(0, 1, 0, e);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.out_vld_o !== 1'b1 || bus.out_dat_o !== 48'h0003_0002_0001 || level !== 5'd1) begin
        n_fail++;
        $display("FAIL single_hold: vld=%b dat=%h lvl=%0d, want 1 000300020001 1",
                 bus.out_vld_o, bus.out_dat_o, level);
      end
      step(0, 0, 0, '0);
    end
    step(0, 0, 1, '0);
    n_checks++;
    if (bus.out_vld_o !== 1'b0 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL single_pop: vld=%b lvl=%0d, want 0 0", bus.out_vld_o, level);
    end
  endtask

  task automatic test_fill_overflow();
    step(1, 0, 0, '0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, W'(i));
      n_checks++;
      if (level !== 5'(i + 1) || afull !== (i + 1 >= AF) || bus.in_rdy_o !== (i + 1 < DP)) begin
        n_fail++;
        $display("FAIL fill[%0d]: lvl=%0d af=%b rdy=%b, want %0d %b %b", i, level, afull,
                 bus.in_rdy_o, i + 1, (i + 1 >= AF), (i + 1 < DP));
      end
    end
    step(0, 1, 0, W'(99));
    n_checks++;
    if (ovf !== 1'b1 || level !== 5'd16) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b lvl=%0d, want 1 16", ovf, level);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (bus.out_vld_o !== 1'b1 || bus.out_dat_o !== W'(i)) begin
        n_fail++;
        $display("FAIL drain[%0d]: vld=%b dat=%0d, want 1 %0d", i, bus.out_vld_o, bus.out_dat_o, i);
      end
      step(0, 0, 1, '0);
    end
    n_checks++;
    if (bus.out_vld_o !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: vld=%b ovf=%b, want 0 1", bus.out_vld_o, ovf);
    end
  endtask

  task automatic test_stream();
    int nxt_out;
    step(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, W'(1000 + i));
    nxt_out = 1000;
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if (bus.out_dat_o !== W'(nxt_out)) begin
        n_fail++;
        $display("FAIL stream_dat[%0d]: dat=%0d, want %0d", i, bus.out_dat_o, nxt_out);
      end
      step(0, 1, 1, W'(1005 + i));
      nxt_out++;
      n_checks++;
      if (level !== 5'd5) begin
        n_fail++;
        $display("FAIL stream_lvl[%0d]: lvl=%0d, want 5", i, level);
      end
    end
  endtask

  task automatic test_full_simul();
    step(1, 0, 0, '0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, W'(200 + i));
    step(0, 1, 1, W'(777));
    n_checks++;
    if (level !== 5'd15 || ovf !== 1'b1 || bus.out_dat_o !== W'(201)) begin
      n_fail++;
      $display("FAIL full_simul: lvl=%0d ovf=%b head=%0d, want 15 1 201", level, ovf, bus.out_dat_o);
    end
    for (int i = 0; i < 15; i++) step(0, 0, 1, '0);
    n_checks++;
    if (level !== 5'd0 || bus.out_vld_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_simul_drop: lvl=%0d vld=%b, want 0 0", level, bus.out_vld_o);
    end
  endtask

  task automatic test_clear();
    step(1, 0, 0, '0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, W'(i));
    step(0, 1, 0, W'(5));
    for (int i = 0; i < 9; i++) step(0, 0, 1, '0);
    n_checks++;
    if (level !== 5'd7 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_pre: lvl=%0d ovf=%b, want 7 1", level, ovf);
    end
    step(1, 1, 1, W'(55));
    n_checks++;
    if (level !== 5'd0 || bus.out_vld_o !== 1'b0 || ovf !== 1'b0 || peak !== 5'd0 ||
        afull !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: lvl=%0d vld=%b ovf=%b pk=%0d af=%b, want 0 0 0 0 0",
               level, bus.out_vld_o, ovf, peak, afull);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) step(0, 1, 0, W'(300 + i));
    @(negedge clk); bus.in_vld_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (level !== 5'd0 || bus.out_vld_o !== 1'b0 || bus.in_rdy_o !== 1'b1 ||
        afull !== 1'b0 || ovf !== 1'b0 || peak !== 5'd0) begin
      n_fail++;
      $display("FAIL async_rst: lvl=%0d vld=%b rdy=%b af=%b ovf=%b pk=%0d, want 0 0 1 0 0 0",
               level, bus.out_vld_o, bus.in_rdy_o, afull, ovf, peak);
    end
    @(negedge clk); rst = 1'b1;
    step(0, 1, 0, W'(4242));
    n_checks++;
    if (level !== 5'd1 || bus.out_vld_o !== 1'b1 || bus.out_dat_o !== W'(4242)) begin
      n_fail++;
      $display("FAIL async_rst_push: lvl=%0d vld=%b dat=%0d, want 1 1 4242",
               level, bus.out_vld_o, bus.out_dat_o);
    end
    step(0, 0, 1, '0);
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    bit c, v, r;
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom};
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 75 : 35));
      r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 75));
      step(c, v, r, d);
      n_checks++;
      if (level !== 5'(mq.size()) || bus.out_vld_o !== (mq.size() > 0) ||
          bus.in_rdy_o !== (mq.size() < DP) || afull !== (mq.size() >= AF) ||
          ovf !== m_ovf || peak !== 5'(exp_peak()) ||
          (mq.size() > 0 && bus.out_dat_o !== mq[0])) begin
        n_fail++;
        $display("FAIL random[%0d]: lvl=%0d vld=%b rdy=%b af=%b ovf=%b pk=%0d dat=%h, want lvl=%0d ovf=%b pk=%0d head=%h",
                 i, level, bus.out_vld_o, bus.in_rdy_o, afull, ovf, peak, bus.out_dat_o,
                 mq.size(), m_ovf, exp_peak(), (mq.size() > 0) ? mq[0] : '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_stream();
    test_full_simul();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
